// File: rtl/program_loader.sv
// Loads a framed program image (count, BPW bytes per word MSB first, checksum) into instruction memory.
// Latency: write strobe one cycle after a word's last byte; done/error one cycle after the checksum byte.
// Backpressure: rx_ready is high in every loading state, including write cycles; it is low otherwise.
module program_loader #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 24,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BPW  = DATA_W / 8;
    localparam int BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [BI_W-1:0]   B_ONE    = BI_W'(1);
    localparam logic [BI_W-1:0]   B_LAST   = BI_W'(BPW - 1);
    localparam logic [TO_W-1:0]   T_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0]   T_LAST   = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit                TO_EN    = (TIMEOUT_CYC > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;
    logic              hold_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] word_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] asm_q;
    logic [7:0]        sum_q;
    logic [BI_W-1:0]   bidx_q;
    logic [TO_W-1:0]   tmo_q;

    logic              hs_d;
    logic [7:0]        sum_d;
    logic [DATA_W-1:0] asm_d;
    logic              tmo_exp_d;

    // busy_q is exactly "in COUNT, DATA or CHECK", so it doubles as rx_ready
    assign hs_d      = rx_valid && busy_q;
    assign sum_d     = sum_q + rx_data;
    assign asm_d     = (asm_q << 8) | DATA_W'(rx_data);
    assign tmo_exp_d = TO_EN && (tmo_q == T_LAST);

    // Loader FSM: frame parsing, word assembly, write strobes, checksum and timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            word_q    <= '0;
            last_q    <= '0;
            asm_q     <= '0;
            sum_q     <= '0;
            bidx_q    <= '0;
            tmo_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q <= S_COUNT;
                        busy_q  <= 1'b1;
                        hold_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        sum_q   <= '0;
                        word_q  <= '0;
                        bidx_q  <= '0;
                        tmo_q   <= '0;
                    end
                end
                S_COUNT, S_DATA, S_CHECK: begin
                    if (hs_d) begin
                        tmo_q <= '0;
                        sum_q <= sum_d;
                        case (state_q)
                            S_COUNT: begin
                                // count 0 wraps to the all-ones last index, i.e. a full memory
                                last_q  <= ADDR_W'(rx_data) - A_ONE;
                                state_q <= S_DATA;
                            end
                            S_DATA: begin
                                asm_q <= asm_d;
                                if (bidx_q == B_LAST) begin
                                    bidx_q    <= '0;
                                    wr_en_q   <= 1'b1;
                                    wr_addr_q <= word_q;
                                    wr_data_q <= asm_d;
                                    word_q    <= word_q + A_ONE;
                                    if (word_q == last_q) begin
                                        state_q <= S_CHECK;
                                    end
                                end else begin
                                    bidx_q <= bidx_q + B_ONE;
                                end
                            end
                            default: begin
                                busy_q <= 1'b0;
                                if (sum_d == 8'd0) begin
                                    state_q <= S_DONE;
                                    done_q  <= 1'b1;
                                    hold_q  <= 1'b0;
                                end else begin
                                    state_q <= S_ERR;
                                    error_q <= 1'b1;
                                end
                            end
                        endcase
                    end else if (tmo_exp_d) begin
                        // CPU stays held; a write registered earlier still drives out this cycle
                        state_q <= S_ERR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (TO_EN) begin
                        tmo_q <= tmo_q + T_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = hold_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader against a frame-level reference model.
// Latency: checks sampled 1 time unit after the active edge; strobes captured on the falling edge.
// Backpressure: stimulus waits on rx_ready with a bounded per-byte wait.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  got_addr[$];
    logic [23:0] got_data[$];
    logic [7:0]  frame[$];
    logic [7:0]  exp_addr[$];
    logic [23:0] exp_data[$];
    bit          exp_ok;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W     (8),
        .DATA_W     (24),
        .TIMEOUT_CYC(20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    // Capture every write strobe for later comparison against the model
    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte after an optional stall and wait (bounded) for its handshake
    task automatic send_byte(input logic [7:0] b, input int stall);
        logic rdy;
        bit   ok;
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (stall) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            rdy = rx_ready;
            tick();
            if (rdy) ok = 1'b1;
        end
        rx_valid = 1'b0;
        check_val("hs_wait", 32'(ok), 32'd1);
    endtask

    // Reference: words are consecutive byte triples after the count; image good iff bytes sum to 0 mod 256
    task automatic build_model();
        int n;
        int s;
        n = (frame[0] == 8'd0) ? 256 : int'(frame[0]);
        s = 0;
        exp_addr.delete();
        exp_data.delete();
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(8'(w));
            exp_data.push_back({frame[1 + 3 * w], frame[2 + 3 * w], frame[3 + 3 * w]});
        end
        foreach (frame[i]) s += int'(frame[i]);
        exp_ok = ((s % 256) == 0);
    endtask

    task automatic run_frame(input string tag, input int max_stall);
        int nw;
        got_addr.delete();
        got_data.delete();
        build_model();
        pulse_start();
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        check_val({tag, "_hold_load"}, 32'(cpu_hold), 32'd1);
        foreach (frame[i]) send_byte(frame[i], (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
        check_val({tag, "_done"}, 32'(done), 32'(exp_ok));
        check_val({tag, "_error"}, 32'(error), 32'(!exp_ok));
        check_val({tag, "_hold_end"}, 32'(cpu_hold), 32'(!exp_ok));
        check_val({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        nw = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < nw; i++) begin
            check_val($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            check_val($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
        end
    endtask

    function automatic logic [7:0] balance(input logic [7:0] q[$]);
        int s;
        s = 0;
        foreach (q[i]) s += int'(q[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    initial begin
        #800000;
        $display("FAIL watchdog got=no_finish exp=finish");
        $fatal(1);
    end

    initial begin
        // Reset with traffic present
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h55;
        tick();
        tick();
        check_val("rst_outs", {wr_en, rx_ready, cpu_hold, busy, done, error}, 32'd0);
        check_val("rst_addr", 32'(wr_addr), 32'd0);
        check_val("rst_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        rx_valid = 1'b0;
        tick();
        check_val("idle_ready", 32'(rx_ready), 32'd0);
        check_val("rst_nwr", 32'(got_addr.size()), 32'd0);

        // Directed good and bad images
        frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFB};
        run_frame("good", 0);
        frame = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hFA};
        run_frame("bad", 0);

        // New start clears error; then stall mid-frame to hit the timeout
        got_addr.delete();
        got_data.delete();
        pulse_start();
        check_val("restart_err", 32'(error), 32'd0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        repeat (19) tick();
        check_val("to_early_err", 32'(error), 32'd0);
        check_val("to_early_rdy", 32'(rx_ready), 32'd1);
        tick();
        check_val("to_err", 32'(error), 32'd1);
        check_val("to_rdy", 32'(rx_ready), 32'd0);
        check_val("to_hold", 32'(cpu_hold), 32'd1);
        check_val("to_done", 32'(done), 32'd0);
        check_val("to_nwr", 32'(got_addr.size()), 32'd0);

        // Full 256-word image with random stalls
        frame.delete();
        frame.push_back(8'h00);
        for (int i = 0; i < 768; i++) frame.push_back(8'($urandom));
        frame.push_back(balance(frame));
        run_frame("full", 4);

        // Short random images, odd ones with a corrupted checksum
        for (int k = 0; k < 4; k++) begin
            int n;
            n = int'($urandom_range(6, 1));
            frame.delete();
            frame.push_back(8'(n));
            for (int i = 0; i < 3 * n; i++) frame.push_back(8'($urandom));
            frame.push_back(balance(frame) + ((k % 2 == 1) ? 8'($urandom_range(255, 1)) : 8'd0));
            run_frame($sformatf("rnd%0d", k), 3);
        end

        // Start mid-load is ignored; reset after four bytes aborts the load
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        pulse_start();
        check_val("midstart_busy", 32'(busy), 32'd1);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h44;
        tick();
        check_val("midrst_outs", {wr_en, rx_ready, cpu_hold, busy, done, error}, 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        rx_valid = 1'b0;
        check_val("midrst_rdy", 32'(rx_ready), 32'd0);
        check_val("midrst_nwr", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) begin
            check_val("midrst_addr", 32'(got_addr[0]), 32'h00);
            check_val("midrst_data", 32'(got_data[0]), 32'h112233);
        end

        // Reset beats a simultaneous start
        start = 1'b1;
        rst = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        check_val("rst_vs_start_busy", 32'(busy), 32'd0);
        check_val("rst_vs_start_hold", 32'(cpu_hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream writer that fills the CPU's 256-entry instruction memory, which the program counter reads one 24-bit word per address. It receives a framed program image: a count byte, then 3 bytes per instruction (MSB first), then a checksum byte. It issues one write strobe per assembled instruction and holds the CPU in reset while loading. On success it releases the CPU; on checksum failure or inter-byte timeout it keeps the CPU held and flags an error.

Parameters:
ADDR_W, 8, instruction memory address width; a count byte of 0 means 2^ADDR_W words.
DATA_W, 24, instruction word width; must be a multiple of 8; bytes per word BPW = DATA_W/8.
TIMEOUT_CYC, 1000, idle cycles allowed between accepted bytes while loading; 0 disables the timeout.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
rx_data  in  8  incoming byte.
rx_valid  in  1  rx_data is valid.
rx_ready  out  1  loader accepts a byte this cycle.
wr_en  out  1  one-cycle instruction-memory write strobe.
wr_addr  out  ADDR_W  write address.
wr_data  out  DATA_W  write data.
cpu_hold  out  1  holds the CPU in reset; drive into the CPU's rst input (OR'd with system rst).
busy  out  1  high in COUNT, DATA and CHECK.
done  out  1  level; load completed with a good checksum.
error  out  1  level; checksum mismatch or timeout.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; all outputs 0, including rx_ready, cpu_hold, done, error, wr_en, wr_addr and wr_data.
- Handshake: a byte is accepted on any cycle where rx_valid && rx_ready. rx_ready = 1 exactly when the state is COUNT, DATA or CHECK, including write cycles, so there are no bubbles.
- States:
  - IDLE/DONE/ERR, start=1: go to COUNT. Set cpu_hold=1, clear done and error, sum=0, word index=0, byte index=0, timeout counter=0. start is ignored in all other states.
  - COUNT: accept a byte to N. N=0 loads 2^ADDR_W words. sum += byte. Go to DATA.
  - DATA: shift each byte into the assembly register, MSB first, and add it to sum.
    - On the BPW-th byte: on the next cycle wr_en=1 for exactly one cycle, wr_addr = word index, wr_data = assembled word. Then increment the word index.
    - After the final word's last byte, go to CHECK. The final write strobe still occurs in CHECK's first cycle.
  - CHECK: accept the checksum byte. If (sum + byte) mod 256 == 0, go to DONE: done=1, cpu_hold=0. Otherwise go to ERR: error=1, cpu_hold stays 1.
- Arithmetic: sum is 8-bit and wraps modulo 256. The word index is ADDR_W bits; for N=0 the final write is at the all-ones address.
- Timeout (TIMEOUT_CYC > 0): a counter increments every busy cycle without a handshake and clears on each handshake.
  - If the counter reaches TIMEOUT_CYC-1 with no handshake, the next state is ERR.
  - error rises TIMEOUT_CYC cycles after the last handshake (or after start).
  - A write pending at that point still completes.
- rst mid-load: the next cycle is IDLE with all outputs 0, and cpu_hold drops. Words already written are not undone.
- Simultaneous start and rst: rst wins.
- wr_addr and wr_data hold their last values between strobes.

Test Plan:
- Reset: assert rst for 2 cycles with rx_valid=1 -> all outputs 0, no wr_en.
- Good load: start, then bytes 02 12 34 56 AB CD EF FB with rx_valid held -> wr_en at addr 0 with data 0x123456 and at addr 1 with data 0xABCDEF. done=1, cpu_hold=0 one cycle after the FB handshake.
- Bad checksum: same stream ending in FA -> error=1, done=0, cpu_hold=1; both writes still occur. A new start clears error.
- Timeout: TIMEOUT_CYC=20; send 01 AA, then drop rx_valid -> error=1 exactly 20 cycles after the AA handshake, rx_ready=0, no wr_en.
- Full image: N=00, 768 data bytes with random stalls, plus the correct checksum -> 256 strobes at addresses 0..255 in order, each carrying the matching word; done=1.
- Reset/start interaction: pulse start mid-load -> ignored. Assert rst after 4 accepted bytes -> next cycle IDLE, cpu_hold=0, no further wr_en.
